// File: rtl/wave_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wave_gen_pkg
//  Description : Shared types and constants for the waveform stimulus
//                generator: channel mode encoding, FSM state encoding and
//                Galois LFSR tap masks per legal channel width.
//  Revision    : 1.0  initial release
// ============================================================================
package wave_gen_pkg;

    // Channel modes. Codes 5..7 are reserved and behave as HOLD.
    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        UP     = 3'd1,
        DOWN   = 3'd2,
        LFSR   = 3'd3,
        TOGGLE = 3'd4
    } wave_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } wave_state_e;

    // Right-shift Galois tap masks (maximal length for each width).
    localparam logic [7:0]  TAPS8  = 8'hB8;
    localparam logic [15:0] TAPS16 = 16'hB400;
    localparam logic [31:0] TAPS32 = 32'h80200003;

    // Tap mask for a channel width, zero-extended to 32 bits.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] w_taps;
        case (width)
            8:       w_taps = {24'h0, TAPS8};
            16:      w_taps = {16'h0, TAPS16};
            default: w_taps = TAPS32;
        endcase
        return w_taps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wave_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : wave_gen_if
//  Description : Configuration write channel of the waveform generator.
//                A write is accepted when cfg_valid && cfg_ready at the
//                rising edge of clk.
//  Ports       : cfg_valid  master->slave  write request
//                cfg_ready  slave->master  write acceptance
//                cfg_ch     master->slave  target channel
//                cfg_mode   master->slave  channel mode (wave_mode_e code)
//                cfg_seed   master->slave  initial channel value
//  Revision    : 1.0  initial release
// ============================================================================
interface wave_gen_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8
) ();
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [2:0]       cfg_mode;
    logic [WIDTH-1:0] cfg_seed;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_mode,
        output cfg_seed,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_mode,
        input  cfg_seed,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/wave_gen_ch.sv
`default_nettype none
// ============================================================================
//  Module      : wave_gen_ch
//  Description : One waveform channel: mode and value registers plus the
//                per-mode next-value logic. Optional wrap pulse when the
//                WAVE_GEN_WRAP_EN macro is defined.
//  Ports       : clk       clock, rising edge
//                reset     synchronous active-high reset
//                cfg_we    load mode/seed this cycle
//                cfg_mode  mode to load
//                cfg_seed  value to load (zero becomes 1 in LFSR mode)
//                adv       advance the value once this cycle
//                value     registered channel value
//                wrap      (WAVE_GEN_WRAP_EN only) UP/DOWN wrap pulse
//  Revision    : 1.0  initial release
// ============================================================================
module wave_gen_ch
    import wave_gen_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_seed,
    input  logic             adv,
    output logic [WIDTH-1:0] value
`ifdef WAVE_GEN_WRAP_EN
    ,
    output logic             wrap
`endif
);

    localparam logic [WIDTH-1:0] c_taps = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] c_one  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]       r_mode;
    logic [WIDTH-1:0] r_value;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] w_seed;

    // An all-zero LFSR state would lock up, so it is replaced on load.
    assign w_seed = ((cfg_mode == LFSR) && (cfg_seed == '0)) ? c_one : cfg_seed;

    always_comb begin
        w_next = r_value;
        case (r_mode)
            UP:      w_next = r_value + c_one;
            DOWN:    w_next = r_value - c_one;
            LFSR:    w_next = r_value[0] ? ((r_value >> 1) ^ c_taps) : (r_value >> 1);
            TOGGLE:  w_next = ~r_value;
            default: w_next = r_value;
        endcase
    end

    // Writes only occur in IDLE and advances only in RUN, so the two
    // branches never compete; the ordering is just for clarity.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode  <= HOLD;
            r_value <= '0;
        end else if (cfg_we) begin
            r_mode  <= cfg_mode;
            r_value <= w_seed;
        end else if (adv) begin
            r_value <= w_next;
        end
    end

    assign value = r_value;

`ifdef WAVE_GEN_WRAP_EN
    logic r_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= adv && (((r_mode == UP) && (&r_value)) ||
                              ((r_mode == DOWN) && (r_value == '0)));
        end
    end

    assign wrap = r_wrap;
`endif

endmodule
`default_nettype wire

// File: rtl/wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : wave_gen
//  Description : Multi-channel waveform stimulus generator. NUM_CH channels
//                of WIDTH bits each hold, count up/down, step an LFSR or
//                toggle once per cycle while in RUN. A programmable start
//                delay (DELAY state) precedes RUN after every run request.
//  Ports       : clk        clock, rising edge
//                reset      synchronous active-high reset
//                cfg        configuration write channel (wave_gen_if.slave)
//                run        level-sensitive run request
//                start_dly  cycles spent in DELAY, sampled on leaving IDLE
//                active     high while in RUN (registered)
//                wave_out   channel i at [i*WIDTH +: WIDTH] (registered)
//                wrap       per-channel wrap pulse, present only when
//                           WAVE_GEN_WRAP_EN is defined
//  Revision    : 1.0  initial release
// ============================================================================
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int DLY_W  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    wave_gen_if.slave               cfg,
    input  logic                    run,
    input  logic [DLY_W-1:0]        start_dly,
    output logic                    active,
    output logic [NUM_CH*WIDTH-1:0] wave_out
`ifdef WAVE_GEN_WRAP_EN
    ,
    output logic [NUM_CH-1:0]       wrap
`endif
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [DLY_W-1:0] c_dly_one = {{(DLY_W-1){1'b0}}, 1'b1};

    wave_state_e      r_state;
    logic [DLY_W-1:0] r_dly;
    logic             r_active;
    logic             r_cfg_ready;
    logic             w_accept;
    logic             w_adv;

    // r_cfg_ready mirrors "state is IDLE", except that it is held low on
    // the reset edge so nothing is accepted coming out of reset.
    assign w_accept = cfg.cfg_valid && r_cfg_ready;
    assign w_adv    = (r_state == RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_dly       <= '0;
            r_active    <= 1'b0;
            r_cfg_ready <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (run) begin
                        r_cfg_ready <= 1'b0;
                        if (start_dly == '0) begin
                            r_state  <= RUN;
                            r_active <= 1'b1;
                        end else begin
                            r_state <= DELAY;
                            r_dly   <= start_dly;
                        end
                    end else begin
                        r_cfg_ready <= 1'b1;
                    end
                end
                DELAY: begin
                    if (!run) begin
                        r_state     <= IDLE;
                        r_cfg_ready <= 1'b1;
                    end else begin
                        r_dly <= r_dly - c_dly_one;
                        if (r_dly == c_dly_one) begin
                            r_state  <= RUN;
                            r_active <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // The edge that samples run low still advances the
                    // channels (w_adv is based on the current state).
                    if (!run) begin
                        r_state     <= IDLE;
                        r_active    <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_active    <= 1'b0;
                    r_cfg_ready <= 1'b1;
                end
            endcase
        end
    end

    assign active        = r_active;
    assign cfg.cfg_ready = r_cfg_ready;

    // Out-of-range channel indices match no instance, so such writes are
    // accepted and dropped.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic w_we;

        assign w_we = w_accept && (cfg.cfg_ch == CH_W'(i));

`ifdef WAVE_GEN_WRAP_EN
        wave_gen_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .cfg_we   (w_we),
            .cfg_mode (cfg.cfg_mode),
            .cfg_seed (cfg.cfg_seed),
            .adv      (w_adv),
            .value    (wave_out[i*WIDTH +: WIDTH]),
            .wrap     (wrap[i])
        );
`else
        wave_gen_ch #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .cfg_we   (w_we),
            .cfg_mode (cfg.cfg_mode),
            .cfg_seed (cfg.cfg_seed),
            .adv      (w_adv),
            .value    (wave_out[i*WIDTH +: WIDTH])
        );
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wave_gen
//  Description : Directed self-checking bench for wave_gen with five 8-bit
//                channels (five channels so that cfg_ch can address an
//                out-of-range channel). Wrap checks are compiled in when
//                WAVE_GEN_WRAP_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wave_gen;
    import wave_gen_pkg::*;

    localparam int NUM_CH = 5;
    localparam int WIDTH  = 8;
    localparam int DLY_W  = 16;

    logic                    clk;
    logic                    reset;
    logic                    run;
    logic [DLY_W-1:0]        start_dly;
    logic                    active;
    logic [NUM_CH*WIDTH-1:0] wave_out;
`ifdef WAVE_GEN_WRAP_EN
    logic [NUM_CH-1:0]       wrap;
`endif

    int n_vec = 0;
    int n_err = 0;

    wave_gen_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) u_if ();

    wave_gen #(
        .NUM_CH (NUM_CH),
        .WIDTH  (WIDTH),
        .DLY_W  (DLY_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg       (u_if.slave),
        .run       (run),
        .start_dly (start_dly),
        .active    (active),
        .wave_out  (wave_out)
`ifdef WAVE_GEN_WRAP_EN
        ,
        .wrap      (wrap)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int ch, input logic [2:0] mode, input logic [7:0] seed);
        u_if.cfg_valid = 1'b1;
        u_if.cfg_ch    = 3'(ch);
        u_if.cfg_mode  = mode;
        u_if.cfg_seed  = seed;
        step();
        u_if.cfg_valid = 1'b0;
    endtask

    logic       zero_seen;
    logic       early_repeat;
    logic [7:0] ch2;

    initial begin
        reset          = 1'b1;
        run            = 1'b0;
        start_dly      = '0;
        u_if.cfg_valid = 1'b0;
        u_if.cfg_ch    = '0;
        u_if.cfg_mode  = '0;
        u_if.cfg_seed  = '0;

        // ---- reset ----
        step();
        step();
        check("rst_wave",   64'(wave_out), 64'h0);
        check("rst_active", 64'(active), 64'h0);
        check("rst_ready",  64'(u_if.cfg_ready), 64'h0);
        reset = 1'b0;
        step();
        check("idle_ready", 64'(u_if.cfg_ready), 64'h1);
        check("idle_wave",  64'(wave_out), 64'h0);

        // ---- run with every channel in HOLD ----
        run = 1'b1;
        step();
        check("hold_active", 64'(active), 64'h1);
        step();
        step();
        check("hold_wave", 64'(wave_out), 64'h0);
        run = 1'b0;
        step();
        check("hold_stop_active", 64'(active), 64'h0);
        check("hold_stop_ready",  64'(u_if.cfg_ready), 64'h1);

        // ---- configuration ----
        cfg_write(0, UP,     8'hFE);
        cfg_write(1, DOWN,   8'h01);
        cfg_write(2, LFSR,   8'h00);
        cfg_write(3, TOGGLE, 8'h5A);
        cfg_write(4, HOLD,   8'h33);
        check("cfg_wave", 64'(wave_out), 64'h335A0101FE);
        cfg_write(5, UP, 8'hAA);
        check("cfg_oob_wave", 64'(wave_out), 64'h335A0101FE);

        // ---- run, start_dly = 0 ----
        run = 1'b1;
        step();
        check("run0_active", 64'(active), 64'h1);
        check("run0_nochg",  64'(wave_out), 64'h335A0101FE);
        step();
        check("run0_s1", 64'(wave_out), 64'h33A5B800FF);
`ifdef WAVE_GEN_WRAP_EN
        check("wrap_s1", 64'(wrap), 64'h00);
`endif
        step();
        check("run0_s2", 64'(wave_out), 64'h335A5CFF00);
`ifdef WAVE_GEN_WRAP_EN
        check("wrap_s2", 64'(wrap), 64'h03);
`endif
        check("run_ready_low", 64'(u_if.cfg_ready), 64'h0);
        // Attempted write while running must be ignored.
        cfg_write(4, UP, 8'h77);
        check("run0_s3", 64'(wave_out), 64'h33A52EFE01);
`ifdef WAVE_GEN_WRAP_EN
        check("wrap_s3", 64'(wrap), 64'h00);
`endif
        run = 1'b0;
        step();
        check("drop_wave",   64'(wave_out), 64'h335A17FD02);
        check("drop_active", 64'(active), 64'h0);
        step();
        check("drop_frozen", 64'(wave_out), 64'h335A17FD02);
        check("drop_ready",  64'(u_if.cfg_ready), 64'h1);

        // ---- LFSR period: 255 updates return ch2 to 17 without a zero ----
        zero_seen    = 1'b0;
        early_repeat = 1'b0;
        run = 1'b1;
        step();
        for (int i = 1; i <= 255; i++) begin
            step();
            ch2 = wave_out[2*WIDTH +: WIDTH];
            if (ch2 == 8'h00) zero_seen = 1'b1;
            if ((ch2 == 8'h17) && (i < 255)) early_repeat = 1'b1;
        end
        check("lfsr_period", 64'(wave_out[2*WIDTH +: WIDTH]), 64'h17);
        check("lfsr_nozero", 64'(zero_seen), 64'h0);
        check("lfsr_early",  64'(early_repeat), 64'h0);
        run = 1'b0;
        step();
        check("lfsr_drop_wave", 64'(wave_out), 64'h335AB3FD02);

        // ---- start_dly = 5 ----
        start_dly = 16'd5;
        run = 1'b1;
        step();
        check("dly_k_active", 64'(active), 64'h0);
        step();
        step();
        step();
        step();
        check("dly_k4_active", 64'(active), 64'h0);
        check("dly_k4_wave",   64'(wave_out), 64'h335AB3FD02);
        step();
        check("dly_k5_active", 64'(active), 64'h1);
        check("dly_k5_wave",   64'(wave_out), 64'h335AB3FD02);
        step();
        check("dly_k6_wave",   64'(wave_out), 64'h33A5E1FC03);
        run = 1'b0;
        step();
        check("dly_drop_wave", 64'(wave_out), 64'h335AC8FB04);

        // ---- run dropped in the middle of DELAY ----
        run = 1'b1;
        step();
        step();
        step();
        run = 1'b0;
        step();
        check("abort_active", 64'(active), 64'h0);
        check("abort_wave",   64'(wave_out), 64'h335AC8FB04);
        step();
        check("abort_ready",  64'(u_if.cfg_ready), 64'h1);
        check("abort_frozen", 64'(wave_out), 64'h335AC8FB04);

        // ---- reset in the middle of RUN ----
        start_dly = 16'd0;
        run = 1'b1;
        step();
        step();
        check("pre_rst_wave", 64'(wave_out), 64'h33A564FA05);
        reset = 1'b1;
        step();
        check("midrst_wave",   64'(wave_out), 64'h0);
        check("midrst_active", 64'(active), 64'h0);
        check("midrst_ready",  64'(u_if.cfg_ready), 64'h0);
        reset = 1'b0;
        run   = 1'b0;
        step();
        check("post_rst_ready", 64'(u_if.cfg_ready), 64'h1);
        // Modes are back to HOLD: running changes nothing.
        run = 1'b1;
        step();
        step();
        step();
        check("post_rst_hold", 64'(wave_out), 64'h0);
        check("post_rst_active", 64'(active), 64'h1);
        run = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
